// File: rtl/front_panel_pkg.sv
// Shared types and constants for the front-panel scan controller.
package front_panel_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam int SEG_W   = 8;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/scan_tick_gen.sv
// Programmable tick prescaler with a pending divisor that is applied only on a tick
// boundary (or immediately while the scanner is idle), so a running period is never cut short.
module scan_tick_gen
  import front_panel_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_RESET = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 cfg_load,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 tick,
  output logic                 update_applied
);
  logic [DIV_WIDTH-1:0] div_active;
  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] pend_div;
  logic [DIV_WIDTH-1:0] div_clamped;
  logic                 pend_vld;

  assign div_clamped    = (cfg_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : cfg_div;
  assign tick           = !clear && (count == div_active - DIV_WIDTH'(1));
  assign update_applied = pend_vld && (tick || clear);

  // A load can only arrive while nothing is pending, so it never collides with an apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_active <= DIV_WIDTH'(DIV_RESET);
      count      <= '0;
      pend_div   <= '0;
      pend_vld   <= 1'b0;
    end else begin
      if (clear || tick) count <= '0;
      else               count <= count + DIV_WIDTH'(1);

      if (update_applied) begin
        div_active <= pend_div;
        pend_vld   <= 1'b0;
      end else if (cfg_load) begin
        pend_div <= div_clamped;
        pend_vld <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/front_panel_scan_ctrl.sv
// Time-multiplexed digit drive and key-matrix scan: a blanking slot then a drive slot per digit,
// with the key snapshot published (and frame_done pulsed) once per complete frame.
module front_panel_scan_ctrl
  import front_panel_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int ROWS        = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_RESET   = 5000,
  parameter int BLANK_TICKS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cfg_valid,
  input  logic [DIV_WIDTH-1:0]     cfg_div,
  output logic                     cfg_ready,
  input  logic [DIGITS*SEG_W-1:0]  seg_data,
  input  logic [ROWS-1:0]          key_rows,
  output logic [DIGITS-1:0]        digit_sel,
  output logic [SEG_W-1:0]         seg_out,
  output logic [DIGITS*ROWS-1:0]   key_state,
  output logic                     frame_done
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BC_W  = $clog2(BLANK_TICKS + 1);

  scan_state_t            state, state_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [BC_W-1:0]        bcnt, bcnt_nxt;
  logic                   tick, update_applied;
  logic                   sample, frame_last;
  logic [SEG_W-1:0]       seg_latch;
  logic [DIGITS*ROWS-1:0] shadow, shadow_full;

  scan_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_RESET (DIV_RESET)
  ) u_tick (
    .clk            (clk),
    .rst            (rst),
    .clear          (state == IDLE),
    .cfg_load       (cfg_valid && cfg_ready),
    .cfg_div        (cfg_div),
    .tick           (tick),
    .update_applied (update_applied)
  );

  assign sample     = en && (state == DRIVE) && tick;
  assign frame_last = sample && (idx == IDX_W'(DIGITS - 1));

  // The published snapshot must include the sample taken on the final drive tick.
  always_comb begin
    shadow_full = shadow;
    shadow_full[idx*ROWS +: ROWS] = key_rows;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    bcnt_nxt  = bcnt;
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      bcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          bcnt_nxt  = '0;
        end
        BLANK: if (tick) begin
          if (bcnt == BC_W'(BLANK_TICKS - 1)) begin
            state_nxt = DRIVE;
            bcnt_nxt  = '0;
          end else begin
            bcnt_nxt = bcnt + BC_W'(1);
          end
        end
        DRIVE: if (tick) begin
          state_nxt = BLANK;
          idx_nxt   = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      bcnt       <= '0;
      seg_latch  <= '0;
      shadow     <= '0;
      key_state  <= '0;
      frame_done <= 1'b0;
      digit_sel  <= '0;
      seg_out    <= '0;
      cfg_ready  <= 1'b1;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      bcnt       <= bcnt_nxt;
      frame_done <= frame_last;

      if (!en)         shadow <= '0;
      else if (sample) shadow <= shadow_full;
      if (frame_last) key_state <= shadow_full;

      if (state_nxt == BLANK && state != BLANK)
        seg_latch <= seg_data[idx_nxt*SEG_W +: SEG_W];
      digit_sel <= (state_nxt == DRIVE) ? (DIGITS'(1) << idx_nxt) : '0;
      seg_out   <= (state_nxt == DRIVE) ? seg_latch : '0;

      if (cfg_valid && cfg_ready) cfg_ready <= 1'b0;
      else if (update_applied)    cfg_ready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_front_panel_scan_ctrl.sv
// Self-checking bench: directed timing checks plus randomized traffic against a frame-position model.
module tb_front_panel_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int ROWS   = 4;
  localparam int DW     = 16;
  localparam int DRST   = 4;
  localparam int BT     = 1;
  localparam int SPD    = BT + 1;
  localparam int TOT    = DIGITS * SPD;

  logic              clk = 1'b0;
  logic              rst, en, cfg_valid, cfg_ready, frame_done;
  logic [DW-1:0]     cfg_div;
  logic [31:0]       seg_data;
  logic [ROWS-1:0]   key_rows;
  logic [DIGITS-1:0] digit_sel;
  logic [7:0]        seg_out;
  logic [15:0]       key_state;

  int total = 0;
  int bad   = 0;
  bit chk_on   = 0;
  bit dir_keys = 1;

  front_panel_scan_ctrl #(
    .DIGITS(DIGITS), .ROWS(ROWS), .DIV_WIDTH(DW), .DIV_RESET(DRST), .BLANK_TICKS(BT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .seg_data(seg_data), .key_rows(key_rows),
    .digit_sel(digit_sel), .seg_out(seg_out), .key_state(key_state), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model: position in the frame counted in ticks, plus cycles elapsed in the current tick period.
  bit         m_on, m_fd, m_pend_vld;
  int         m_pos, m_cnt, m_div, m_pend;
  logic [3:0] m_keys [DIGITS];
  logic [15:0] m_key_state;
  logic [7:0]  m_seg;

  always @(posedge clk) begin
    bit tk, ap, cp;
    if (rst) begin
      m_on = 0; m_pos = 0; m_cnt = 0; m_div = DRST; m_pend = 0; m_pend_vld = 0;
      m_key_state = '0; m_fd = 0; m_seg = '0;
      for (int i = 0; i < DIGITS; i++) m_keys[i] = '0;
    end else begin
      tk = m_on && (m_cnt == m_div - 1);
      ap = m_pend_vld && (tk || !m_on);
      cp = cfg_valid && !m_pend_vld;
      m_fd = 0;
      if (!en) begin
        m_on = 0; m_pos = 0; m_cnt = 0;
        for (int i = 0; i < DIGITS; i++) m_keys[i] = '0;
      end else if (!m_on) begin
        m_on = 1; m_pos = 0; m_cnt = 0; m_seg = seg_data[7:0];
      end else if (tk) begin
        if (m_pos % SPD == BT) begin
          m_keys[m_pos / SPD] = key_rows;
          if (m_pos / SPD == DIGITS - 1) begin
            for (int i = 0; i < DIGITS; i++) m_key_state[i*ROWS +: ROWS] = m_keys[i];
            m_fd = 1;
          end
        end
        m_pos = (m_pos + 1) % TOT;
        m_cnt = 0;
        if (m_pos % SPD == 0) m_seg = seg_data[(m_pos / SPD)*8 +: 8];
      end else begin
        m_cnt++;
      end
      if (ap) begin m_div = m_pend; m_pend_vld = 0; end
      if (cp) begin m_pend = (int'(cfg_div) < 2) ? 2 : int'(cfg_div); m_pend_vld = 1; end
    end
  end

  function automatic logic [31:0] exp_dsel();
    return (m_on && m_pos % SPD == BT) ? (32'd1 << (m_pos / SPD)) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_seg();
    return (m_on && m_pos % SPD == BT) ? {24'd0, m_seg} : 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("digit_sel", {28'd0, digit_sel}, exp_dsel());
      chk("seg_out", {24'd0, seg_out}, exp_seg());
      chk("key_state", {16'd0, key_state}, {16'd0, m_key_state});
      chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
      chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend_vld});
    end
  end

  task automatic cyc();
    @(negedge clk);
    if (dir_keys) key_rows = (m_on && m_pos / SPD == 0) ? 4'h5 : 4'h0;
  endtask

  initial begin
    int n, en_off;
    rst = 1; en = 0; cfg_valid = 0; cfg_div = '0; seg_data = 32'hA1B2C3D4; key_rows = '0;
    cyc();
    chk_on = 1;
    repeat (2) cyc();
    chk("rst_dsel", {28'd0, digit_sel}, 32'd0);
    chk("rst_seg", {24'd0, seg_out}, 32'd0);
    chk("rst_keys", {16'd0, key_state}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);

    // Scan from reset with divisor 4: slots of 4 cycles, frame of 32.
    rst = 0; cyc(); en = 1;
    for (int c = 1; c <= 65; c++) begin
      cyc();
      if (c == 4)  chk("c4_dsel", {28'd0, digit_sel}, 32'd0);
      if (c == 6)  begin chk("c6_dsel", {28'd0, digit_sel}, 32'd1); chk("c6_seg", {24'd0, seg_out}, 32'hD4); end
      if (c == 14) begin chk("c14_dsel", {28'd0, digit_sel}, 32'd2); chk("c14_seg", {24'd0, seg_out}, 32'hC3); end
      if (c == 22) begin chk("c22_dsel", {28'd0, digit_sel}, 32'd4); chk("c22_seg", {24'd0, seg_out}, 32'hB2); end
      if (c == 30) begin chk("c30_dsel", {28'd0, digit_sel}, 32'd8); chk("c30_seg", {24'd0, seg_out}, 32'hA1); end
      if (c == 32) begin chk("c32_fd", {31'd0, frame_done}, 32'd0); chk("c32_keys", {16'd0, key_state}, 32'd0); end
      if (c == 33) begin chk("c33_fd", {31'd0, frame_done}, 32'd1); chk("c33_keys", {16'd0, key_state}, 32'h5); end
      if (c == 64) chk("c64_keys_hold", {16'd0, key_state}, 32'h5);
      if (c == 65) chk("c65_fd", {31'd0, frame_done}, 32'd1);
    end

    // Divisor 8 written mid-slot: in-flight period stays 4, next drive slot lasts 8.
    cyc();
    cfg_valid = 1; cfg_div = 16'd8;
    cyc(); cfg_valid = 0;
    chk("div8_ready_low", {31'd0, cfg_ready}, 32'd0);
    n = 0; do begin cyc(); n++; end while (cfg_ready !== 1'b1 && n < 100);
    chk("div8_ready_lat", n, 32'd2);
    chk("div8_dsel", {28'd0, digit_sel}, 32'd1);
    n = 0; do begin cyc(); n++; end while (digit_sel === 4'd1 && n < 100);
    chk("div8_period", n, 32'd8);

    // Divisor 1 clamps to 2.
    cfg_valid = 1; cfg_div = 16'd1;
    cyc(); cfg_valid = 0;
    chk("div1_ready_low", {31'd0, cfg_ready}, 32'd0);
    n = 0; do begin cyc(); n++; end while (cfg_ready !== 1'b1 && n < 100);
    chk("div1_dsel", {28'd0, digit_sel}, 32'd2);
    n = 0; do begin cyc(); n++; end while (digit_sel === 4'd2 && n < 100);
    chk("div1_period", n, 32'd2);

    // Drop enable while column 2 is driven.
    n = 0; do begin cyc(); n++; end while (digit_sel !== 4'd4 && n < 200);
    chk("col2_seen", {28'd0, digit_sel}, 32'd4);
    en = 0; cyc();
    chk("off_dsel", {28'd0, digit_sel}, 32'd0);
    chk("off_seg", {24'd0, seg_out}, 32'd0);
    chk("off_keys", {16'd0, key_state}, 32'h5);
    repeat (2) cyc();
    en = 1;
    n = 0; do begin cyc(); n++; end while (frame_done !== 1'b1 && n < 200);
    chk("reen_fd_lat", n, 32'd17);
    chk("reen_keys", {16'd0, key_state}, 32'h5);

    // Reset mid-drive with a divisor update pending.
    n = 0; do begin cyc(); n++; end while (digit_sel === 4'd0 && n < 200);
    cfg_valid = 1; cfg_div = 16'd8;
    cyc(); cfg_valid = 0; rst = 1;
    cyc();
    chk("mrst_dsel", {28'd0, digit_sel}, 32'd0);
    chk("mrst_seg", {24'd0, seg_out}, 32'd0);
    chk("mrst_keys", {16'd0, key_state}, 32'd0);
    chk("mrst_fd", {31'd0, frame_done}, 32'd0);
    chk("mrst_ready", {31'd0, cfg_ready}, 32'd1);
    rst = 0;
    n = 0; do begin cyc(); n++; end while (digit_sel === 4'd0 && n < 100);
    chk("mrst_first_drive", n, 32'd5);
    n = 0; do begin cyc(); n++; end while (digit_sel !== 4'd0 && n < 100);
    chk("mrst_slot_len", n, 32'd4);

    // Randomized traffic.
    dir_keys = 0; en_off = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      key_rows  = ROWS'($urandom);
      cfg_valid = ($urandom % 40 == 0);
      cfg_div   = DW'($urandom_range(0, 6));
      if ($urandom % 50 == 0) seg_data = $urandom;
      rst = ($urandom % 1000 == 0);
      if (en_off > 0) begin
        en_off--;
        en = (en_off == 0);
      end else if ($urandom % 300 == 0) begin
        en = 0; en_off = $urandom_range(1, 5);
      end
    end
    rst = 0; en = 1; cfg_valid = 0;
    repeat (5) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
